// File: rtl/lcd_fb_pkg.sv
// lcd_fb_pkg: shared definitions for the LCD frame-buffer controller.
//   - frame geometry (FB_AW, FB_DEPTH, DW)
//   - capture state encoding used by lcd_fb_wr_seq
//   - MCU bus address map of the frame-buffer block
package lcd_fb_pkg;

    localparam int FB_AW    = 11;
    localparam int FB_DEPTH = 2048;
    localparam int DW       = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        FULL = 2'd2
    } cap_state_e;

    // MCU bus address map (byte addresses, inclusive ranges)
    localparam int unsigned MAP_FB_BASE   = 0;
    localparam int unsigned MAP_FB_LAST   = 2047;
    localparam int unsigned MAP_PARK_BASE = 2048;
    localparam int unsigned MAP_PARK_LAST = 2056;
    localparam int unsigned MAP_IN_BASE   = 2057;
    localparam int unsigned MAP_IN_LAST   = 2058;
    localparam int unsigned MAP_OUT_BASE  = 2059;
    localparam int unsigned MAP_OUT_LAST  = 2060;

endpackage

// File: rtl/lcd_fb_wr_seq.sv
// lcd_fb_wr_seq: capture sequencer. Tracks the write position inside the
// write bank and raises swap_pend once a whole frame has been stored.
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   frm_start_i    frame-begin pulse
//   wr_strb_i      captured-byte strobe
//   swap_i         the top takes the swap on this edge
//   wr_fire_o      a RAM write happens on this edge
//   wr_adr_o       in-bank address for that write
//   swap_pend_o    a full frame waits for a bank swap
//   drop_o         frm_start on this edge discards the incoming frame
module lcd_fb_wr_seq
    import lcd_fb_pkg::*;
#(
    parameter int FB_AW = 11
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             frm_start_i,
    input  logic             wr_strb_i,
    input  logic             swap_i,
    output logic             wr_fire_o,
    output logic [FB_AW-1:0] wr_adr_o,
    output logic             swap_pend_o,
    output logic             drop_o
);

    cap_state_e       state_q, state_d;
    logic [FB_AW:0]   cnt_q, cnt_d;
    logic             pend_q, pend_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        if (swap_i) begin
            // swap outranks a coincident frm_start, which is then dropped
            state_d = IDLE;
            pend_d  = 1'b0;
        end else begin
            unique case (state_q)
                IDLE, FULL: begin
                    if (frm_start_i && !pend_q) begin
                        state_d = FILL;
                        cnt_d   = '0;
                    end
                end
                FILL: begin
                    if (frm_start_i) begin
                        cnt_d = '0;  // restart the same bank, partial frame lost
                    end else if (wr_strb_i) begin
                        cnt_d = cnt_q + 1'b1;
                        if (cnt_q[FB_AW-1:0] == {FB_AW{1'b1}}) begin
                            state_d = FULL;
                            pend_d  = 1'b1;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        wr_fire_o   = (state_q == FILL) && wr_strb_i && !frm_start_i;
        wr_adr_o    = cnt_q[FB_AW-1:0];
        swap_pend_o = pend_q;
        drop_o      = frm_start_i && pend_q && (state_q != FILL);
    end

endmodule

// File: rtl/lcd_fb_ctrl.sv
// lcd_fb_ctrl: ping-pong frame-buffer controller. Captured bytes go to the
// write bank, MCU reads come from the read bank, and the banks swap once a
// frame is complete and the MCU is not holding the read bank.
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   frm_start, wr_strb, wr_data capture stream
//   rd_req, rd_adr, rd_lock     MCU read request / bank hold
//   frm_ack                     clears frm_rdy
//   rd_ack, rd_data             read completion
//   frm_rdy, frm_drop, frm_cnt  frame status
//   ram_we, ram_adr, ram_wdata, ram_rdata  external RAM (MSB of address = bank)
module lcd_fb_ctrl
    import lcd_fb_pkg::*;
#(
    parameter int FB_AW = 11,
    parameter int DW    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             frm_start,
    input  logic             wr_strb,
    input  logic [DW-1:0]    wr_data,
    input  logic             rd_req,
    input  logic [FB_AW-1:0] rd_adr,
    input  logic             rd_lock,
    input  logic             frm_ack,
    output logic             rd_ack,
    output logic [DW-1:0]    rd_data,
    output logic             frm_rdy,
    output logic             frm_drop,
    output logic [7:0]       frm_cnt,
    output logic             ram_we,
    output logic [FB_AW:0]   ram_adr,
    output logic [DW-1:0]    ram_wdata,
    input  logic [DW-1:0]    ram_rdata
);

    logic             rd_bank_q, rd_bank_d;
    logic             rd_pend_q;
    logic             rd_ack_q;
    logic [DW-1:0]    rd_data_q;
    logic             frm_rdy_q;
    logic             frm_drop_q;
    logic [7:0]       frm_cnt_q;
    logic             ram_we_q;
    logic [FB_AW:0]   ram_adr_q;
    logic [DW-1:0]    ram_wdata_q;

    logic             wr_fire;
    logic [FB_AW-1:0] wr_adr;
    logic             swap_pend;
    logic             drop;
    logic             swap;
    logic             rd_accept;

    lcd_fb_wr_seq #(.FB_AW(FB_AW)) u_wr_seq (
        .clk         (clk),
        .rst         (rst),
        .frm_start_i (frm_start),
        .wr_strb_i   (wr_strb),
        .swap_i      (swap),
        .wr_fire_o   (wr_fire),
        .wr_adr_o    (wr_adr),
        .swap_pend_o (swap_pend),
        .drop_o      (drop)
    );

    // A read in flight must finish from its original bank, so swap waits.
    assign swap      = swap_pend && !rd_lock && !rd_pend_q;
    // Any wr_strb blocks read acceptance; the read retries next edge.
    assign rd_accept = rd_req && !rd_pend_q && !wr_strb;
    // Reads accepted on the swap edge already see the new bank.
    assign rd_bank_d = swap ? ~rd_bank_q : rd_bank_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_bank_q   <= 1'b0;
            rd_pend_q   <= 1'b0;
            rd_ack_q    <= 1'b0;
            rd_data_q   <= '0;
            frm_rdy_q   <= 1'b0;
            frm_drop_q  <= 1'b0;
            frm_cnt_q   <= '0;
            ram_we_q    <= 1'b0;
            ram_adr_q   <= '0;
            ram_wdata_q <= '0;
        end else begin
            rd_bank_q <= rd_bank_d;
            ram_we_q  <= wr_fire;
            if (wr_fire) begin
                ram_adr_q   <= {~rd_bank_q, wr_adr};
                ram_wdata_q <= wr_data;
            end else if (rd_accept) begin
                ram_adr_q   <= {rd_bank_d, rd_adr};
            end
            // A read occupies exactly one pending cycle.
            rd_pend_q <= rd_accept;
            rd_ack_q  <= rd_pend_q;
            if (rd_pend_q) begin
                rd_data_q <= ram_rdata;
            end
            frm_drop_q <= drop;
            if (swap) begin
                frm_rdy_q <= 1'b1;  // set wins over a coincident frm_ack
                frm_cnt_q <= frm_cnt_q + 8'd1;
            end else if (frm_ack) begin
                frm_rdy_q <= 1'b0;
            end
        end
    end

    assign rd_ack    = rd_ack_q;
    assign rd_data   = rd_data_q;
    assign frm_rdy   = frm_rdy_q;
    assign frm_drop  = frm_drop_q;
    assign frm_cnt   = frm_cnt_q;
    assign ram_we    = ram_we_q;
    assign ram_adr   = ram_adr_q;
    assign ram_wdata = ram_wdata_q;

endmodule

// File: tb/tb_lcd_fb_ctrl.sv
// tb_lcd_fb_ctrl: directed-vector bench for lcd_fb_ctrl with a behavioural
// registered-address RAM attached to the ram_* port.
module tb_lcd_fb_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        frm_start, wr_strb, rd_req, rd_lock, frm_ack;
    logic [7:0]  wr_data;
    logic [10:0] rd_adr;
    logic        rd_ack, frm_rdy, frm_drop, ram_we;
    logic [7:0]  rd_data, frm_cnt, ram_wdata, ram_rdata;
    logic [11:0] ram_adr;

    logic        preload;
    logic [7:0]  mem [0:4095];
    int          ack_cnt  = 0;
    int          drop_cnt = 0;
    int          n_vec = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    lcd_fb_ctrl #(.FB_AW(11), .DW(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .frm_start (frm_start),
        .wr_strb   (wr_strb),
        .wr_data   (wr_data),
        .rd_req    (rd_req),
        .rd_adr    (rd_adr),
        .rd_lock   (rd_lock),
        .frm_ack   (frm_ack),
        .rd_ack    (rd_ack),
        .rd_data   (rd_data),
        .frm_rdy   (frm_rdy),
        .frm_drop  (frm_drop),
        .frm_cnt   (frm_cnt),
        .ram_we    (ram_we),
        .ram_adr   (ram_adr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata)
    );

    // External RAM: address is registered inside the controller, data out
    // follows it within the next cycle. Bank 0 preloaded with i ^ 0xA5.
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 4096; i++)
                mem[i] <= (i < 2048) ? (8'(i) ^ 8'hA5) : 8'h00;
        end else if (ram_we) begin
            mem[ram_adr] <= ram_wdata;
        end
    end
    assign ram_rdata = mem[ram_adr];

    always @(posedge clk) begin
        if (rd_ack)   ack_cnt  <= ack_cnt + 1;
        if (frm_drop) drop_cnt <= drop_cnt + 1;
    end

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        frm_start = 1'b1;
        tick();
        frm_start = 1'b0;
    endtask

    function automatic logic [7:0] pat(input int kind, input int i);
        case (kind)
            0:       return 8'(i / 8);
            1:       return 8'(i / 8) ^ 8'h55;
            2:       return 8'(i);
            3:       return 8'hEE;
            default: return 8'(i / 4);
        endcase
    endfunction

    task automatic write_frame(input int n, input int kind);
        for (int i = 0; i < n; i++) begin
            wr_strb = 1'b1;
            wr_data = pat(kind, i);
            tick();
            wr_strb = 1'b0;
            tick();
        end
    endtask

    task automatic do_read(input logic [10:0] adr, input logic [7:0] exp, input string tag);
        int lat;
        rd_req = 1'b1;
        rd_adr = adr;
        lat    = 0;
        while (!rd_ack && lat < 8) begin
            tick();
            lat++;
        end
        rd_req = 1'b0;
        check_vec({tag, "_lat"}, lat, 2);
        check_vec({tag, "_data"}, rd_data, exp);
        tick();
        check_vec({tag, "_ack1cyc"}, rd_ack, 0);
    endtask

    task automatic check_zero(input string tag);
        check_vec({tag, "_rd_ack"}, rd_ack, 0);
        check_vec({tag, "_rd_data"}, rd_data, 0);
        check_vec({tag, "_frm_rdy"}, frm_rdy, 0);
        check_vec({tag, "_frm_drop"}, frm_drop, 0);
        check_vec({tag, "_frm_cnt"}, frm_cnt, 0);
        check_vec({tag, "_ram_we"}, ram_we, 0);
        check_vec({tag, "_ram_adr"}, ram_adr, 0);
        check_vec({tag, "_ram_wdata"}, ram_wdata, 0);
    endtask

    initial begin
        int d0, a0;
        rst = 1'b1; preload = 1'b1;
        frm_start = 0; wr_strb = 0; wr_data = 0; rd_req = 0;
        rd_adr = 0; rd_lock = 0; frm_ack = 0;
        repeat (3) tick();
        preload = 1'b0;
        check_zero("reset");
        rst = 1'b0;
        tick();

        // Read/write collision: write wins, read follows one edge later
        pulse_start();
        check_vec("coll_nodrop", frm_drop, 0);
        wr_strb = 1'b1; wr_data = 8'h3C; rd_req = 1'b1; rd_adr = 11'd5;
        tick();
        check_vec("coll_we", ram_we, 1);
        check_vec("coll_wadr", ram_adr, 12'h800);
        check_vec("coll_wdata", ram_wdata, 8'h3C);
        check_vec("coll_noack0", rd_ack, 0);
        wr_strb = 1'b0;
        tick();
        check_vec("coll_rd_we", ram_we, 0);
        check_vec("coll_radr", ram_adr, 12'h005);
        check_vec("coll_noack1", rd_ack, 0);
        tick();
        check_vec("coll_ack", rd_ack, 1);
        check_vec("coll_data", rd_data, 8'hA0);
        rd_req = 1'b0;
        tick();
        check_vec("coll_ack1cyc", rd_ack, 0);

        // Full frame, no lock (restart discards the collision byte)
        pulse_start();
        check_vec("f1_restart_nodrop", frm_drop, 0);
        write_frame(2047, 0);
        wr_strb = 1'b1; wr_data = pat(0, 2047);
        tick();
        check_vec("f1_last_adr", ram_adr, 12'hFFF);
        check_vec("f1_last_we", ram_we, 1);
        check_vec("f1_pre_rdy", frm_rdy, 0);
        check_vec("f1_pre_cnt", frm_cnt, 0);
        wr_strb = 1'b0;
        tick();
        check_vec("f1_rdy", frm_rdy, 1);
        check_vec("f1_cnt", frm_cnt, 1);
        do_read(11'd16, 8'd2, "f1_rd16");
        do_read(11'd2047, 8'd255, "f1_rd2047");
        do_read(11'd5, 8'd0, "f1_rd5");

        // Lock deferral, drop while locked, release coincident with ack+start
        frm_ack = 1'b1; tick(); frm_ack = 1'b0;
        check_vec("ack_clr", frm_rdy, 0);
        rd_lock = 1'b1;
        pulse_start();
        write_frame(2048, 1);
        repeat (3) tick();
        check_vec("lock_cnt", frm_cnt, 1);
        check_vec("lock_rdy", frm_rdy, 0);
        do_read(11'd16, 8'd2, "lock_rd16");
        pulse_start();
        check_vec("lock_drop", frm_drop, 1);
        tick();
        check_vec("lock_drop_1cyc", frm_drop, 0);
        check_vec("lock_cnt2", frm_cnt, 1);
        rd_lock = 1'b0; frm_ack = 1'b1; frm_start = 1'b1;
        tick();
        frm_ack = 1'b0; frm_start = 1'b0;
        check_vec("rel_rdy_ack", frm_rdy, 1);
        check_vec("rel_cnt", frm_cnt, 2);
        check_vec("rel_drop", frm_drop, 1);
        do_read(11'd16, 8'h57, "rel_rd16");
        wr_strb = 1'b1; wr_data = 8'h77;
        tick();
        check_vec("idle_strb_ignored", ram_we, 0);
        wr_strb = 1'b0;
        tick();
        frm_ack = 1'b1; tick(); frm_ack = 1'b0;
        check_vec("ack_alone", frm_rdy, 0);

        // Aborted frame then full frame: one swap, no drop
        d0 = drop_cnt;
        pulse_start();
        write_frame(1000, 3);
        pulse_start();
        write_frame(2048, 2);
        repeat (2) tick();
        check_vec("abort_cnt", frm_cnt, 3);
        check_vec("abort_nodrop", drop_cnt - d0, 0);
        do_read(11'd999, 8'd231, "abort_rd999");
        do_read(11'd1000, 8'd232, "abort_rd1000");

        // Reset mid-FILL and mid-read
        pulse_start();
        write_frame(500, 3);
        rd_req = 1'b1; rd_adr = 11'd3;
        tick();
        a0 = ack_cnt;
        rst = 1'b1; rd_req = 1'b0;
        tick();
        check_zero("midrst");
        rst = 1'b0;
        repeat (3) tick();
        check_vec("midrst_noack", ack_cnt - a0, 0);
        pulse_start();
        write_frame(2048, 4);
        tick();
        check_vec("post_cnt", frm_cnt, 1);
        check_vec("post_rdy", frm_rdy, 1);
        do_read(11'd16, 8'd4, "post_rd16");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
